// File: rtl/cic_pkg.sv
// Shared CIC constants, sample types and the input sign-extension helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cic_pkg;

  localparam int CIC_IW    = 16;
  localparam int CIC_LOG2R = 4;
  localparam int CIC_N     = 3;
  localparam int CIC_OW    = CIC_IW + (CIC_N - 1) * CIC_LOG2R;

  typedef logic signed [CIC_IW-1:0] cic_in_t;
  typedef logic signed [CIC_OW-1:0] cic_acc_t;

  // Widen a raw input sample to the internal accumulator width.
  function automatic cic_acc_t sext_in(input cic_in_t v);
    return {{(CIC_OW - CIC_IW){v[CIC_IW-1]}}, v};
  endfunction

endpackage

// File: rtl/cic_int_stage.sv
// One CIC integrator: registered two's-complement accumulator, wraps freely.
// Latency: 1 clock from add to acc.
// Backpressure: none, accumulates every clock.
//
// Ports:
//   clk, rst (async, active-high), clr (sync clear)
//   add  - signed increment applied every clock
//   acc  - registered running sum
module cic_int_stage #(
  parameter int W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic signed [W-1:0] add,
  output logic signed [W-1:0] acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else begin
      acc <= acc + add;
    end
  end

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: N low-rate combs, zero-stuffing by R, N full-rate integrators.
// Latency: sample accepted at edge t appears on out_dat at edge t+N+2.
// Backpressure: none; pulls one sample every R clocks, a missing sample becomes 0 and sets underflow.
//
// Ports:
//   clk, rst (async, active-high), clr (sync clear, highest priority)
//   in_dat/in_vld  - upstream sample, taken when in_rdy is high
//   in_rdy         - one-cycle request strobe every R clocks
//   out_dat/out_vld - full-rate output stream
//   underflow      - sticky: a request found in_vld low
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int IW    = CIC_IW,
  parameter int LOG2R = CIC_LOG2R,
  parameter int N     = CIC_N,
  parameter int OW    = IW + (N - 1) * LOG2R
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic signed [IW-1:0] in_dat,
  input  logic                 in_vld,
  output logic                 in_rdy,
  output logic signed [OW-1:0] out_dat,
  output logic                 out_vld,
  output logic                 underflow
);

  logic [LOG2R-1:0]     phase;
  logic                 stb_d;    // in_rdy delayed by one: x is valid for the combs
  logic signed [OW-1:0] x;
  logic signed [OW-1:0] u;
  logic signed [OW-1:0] d     [N];
  logic signed [OW-1:0] c_in  [N];  // input of comb stage k
  logic signed [OW-1:0] c_out;      // output of the last comb
  logic signed [OW-1:0] integ [N];
  logic [N+1:0]         vpipe;      // tracks accepted samples until they reach out_dat

  assign in_rdy = (phase == '0) && !rst && !clr;

  // Control, input register and output staging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= '0;
      stb_d     <= 1'b0;
      x         <= '0;
      underflow <= 1'b0;
      vpipe     <= '0;
      out_vld   <= 1'b0;
      out_dat   <= '0;
    end else if (clr) begin
      phase     <= '0;
      stb_d     <= 1'b0;
      x         <= '0;
      underflow <= 1'b0;
      vpipe     <= '0;
      out_vld   <= 1'b0;
      out_dat   <= '0;
    end else begin
      phase <= phase + LOG2R'(1);
      stb_d <= in_rdy;
      if (in_rdy) begin
        x <= in_vld ? {{(OW - IW){in_dat[IW-1]}}, in_dat} : '0;
        if (!in_vld) begin
          underflow <= 1'b1;
        end
      end
      // The first request travels N+2 edges before it lands on out_dat.
      vpipe <= {vpipe[N:0], in_rdy};
      if (vpipe[N+1]) begin
        out_vld <= 1'b1;
      end
      out_dat <= integ[N-1];
    end
  end

  // Comb chain, evaluated combinationally from x against the stage delays.
  always_comb begin
    logic signed [OW-1:0] acc;
    acc = x;
    for (int k = 0; k < N; k++) begin
      c_in[k] = acc;
      acc     = acc - d[k];
    end
    c_out = acc;
  end

  // Comb delays and zero-stuffing upsampler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) d[k] <= '0;
      u <= '0;
    end else if (clr) begin
      for (int k = 0; k < N; k++) d[k] <= '0;
      u <= '0;
    end else begin
      if (stb_d) begin
        for (int k = 0; k < N; k++) d[k] <= c_in[k];
      end
      u <= stb_d ? c_out : '0;
    end
  end

  // Integrator cascade, running every clock.
  for (genvar k = 0; k < N; k++) begin : g_int
    logic signed [OW-1:0] add;
    if (k == 0) begin : g_first
      assign add = u;
    end else begin : g_next
      assign add = integ[k-1];
    end
    cic_int_stage #(.W(OW)) u_stage (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .add (add),
      .acc (integ[k])
    );
  end

endmodule

// File: doc/cic_interpolator.md
Name: cic_interpolator

Overview:
- CIC interpolation filter for the DAC/test-signal path: upsamples a low-rate signed stream by R into a full-clock-rate signed stream.
- This is the inverse direction of the existing cic_filter decimator, which turns the 5-bit ADC stream into 35-bit samples.
- Structure: N comb stages at the low rate, a zero-stuffing upsampler, then N integrator stages running every clock.
- The block requests one input sample per R clocks. It emits one output sample per clock.

Parameters:
- IW, 16, input sample width (signed).
- LOG2R, 4, log2 of interpolation ratio R (R = 16).
- N, 3, number of comb stages and number of integrator stages.
- OW, IW+(N-1)*LOG2R (= 24), output and internal datapath width.

Ports:
- clk  in  1  single system clock.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear: zeroes all filter state, phase counter and flags.
- in_dat  in  IW  signed input sample.
- in_vld  in  1  upstream sample present.
- in_rdy  out  1  one-cycle request strobe, high once every R clocks.
- out_dat  out  OW  signed interpolated sample, valid every clock while out_vld is high.
- out_vld  out  1  output stream valid.
- underflow  out  1  sticky flag: a request was not answered.

Behaviour:
- Reset (rst high, asynchronous):
  - All comb delay registers, integrators, phase counter, out_dat, out_vld and underflow go to 0.
  - in_rdy = 0 while rst is high.
- clr has the same effect as rst, applied at a clock edge. clr has priority over every other event in that cycle.
- Phase counter:
  - LOG2R bits, free-running, increments every clock, wraps from R-1 to 0.
  - in_rdy = 1 iff phase == 0 and not in reset or clr.
  - The first in_rdy comes 1 clock after rst release (phase 0 -> 1 transition sees phase == 0 at the first edge).
- Handshake:
  - A sample is taken in a cycle with in_rdy & in_vld.
  - in_vld outside in_rdy cycles is ignored.
  - If in_rdy = 1 and in_vld = 0, a zero sample is used and underflow is set. underflow stays set until rst/clr.
- Input register x:
  - Loaded on every in_rdy cycle (with in_dat, or 0 on underflow).
  - Sign-extended from IW to OW.
- Combs:
  - Combinational chain from x: c_k = c_{k-1} - d_k, where d_k is the comb-k delay register and c_0 = x.
  - d_k <= c_{k-1} is loaded only in the cycle after an in_rdy cycle (strobe delayed by 1 to align with x).
- Upsampler register u:
  - u <= c_N in the cycle after an in_rdy cycle.
  - u <= 0 in all other cycles (zero-stuffing, R-1 zeros per sample).
- Integrators: i_1 <= i_1 + u, and i_k <= i_k + i_{k-1} for k = 2..N. All registered, updated every clock.
- Arithmetic:
  - All adds and subtracts are OW-bit two's complement with wrap-around.
  - No saturation and no truncation; wrap is intentional and exact because the filter gain R^(N-1) bounds the result to OW bits.
- out_dat <= i_N every clock.
- Latency: a sample accepted at edge t reaches u at t+1, i_N at t+1+N, and out_dat at t+2+N.
- out_vld:
  - Sets to 1 at the edge where the first accepted (or underflow-zero) sample reaches out_dat, i.e. first accept + N + 2.
  - Then stays 1 every cycle until rst/clr.
- DC gain = R^(N-1) = 256. Impulse response length = N*(R-1)+1 = 46 output samples, coefficient sum R^N = 4096.
- Simultaneous clr and in_rdy&in_vld: the sample is discarded and phase restarts at 0.

Decomposition:
- Package cic_pkg holds:
  - constants CIC_IW, CIC_LOG2R, CIC_N, CIC_OW;
  - typedefs cic_in_t (signed [IW-1:0]) and cic_acc_t (signed [OW-1:0]);
  - function sext_in() returning cic_acc_t.
  - cic_filter may later share the same package.
- One sub-module, cic_int_stage: a single OW-bit accumulator with rst/clr. It is instantiated N times via generate.
- The combs stay inline; they are too small to justify a module.

Test Plan:
- in_vld held 1, in_dat = 0 except a single 1 at the first in_rdy -> out_dat shows 46 nonzero samples starting first_accept+N+2, values sum to 4096, first value 1, then 0 thereafter. underflow = 0.
- DC: in_dat = 100 every request, in_vld = 1 -> after transient (>= 3*R clocks) out_dat = 25600 every clock, out_vld = 1.
- Full-scale negative: in_dat = -32768 constant -> out_dat settles at -8388608 exactly (no wrap error). Then switch to +32767 -> settles at 8388352.
- Underflow: in_vld low at one in_rdy -> underflow = 1 from the next edge and stays 1. That sample behaves as 0 in out_dat (compare to golden model).
- Async rst asserted mid-stream between edges -> out_dat, out_vld, in_rdy and underflow are 0 immediately. After release, in_rdy returns with period 16 and the DC test re-converges.
- clr asserted for 1 cycle mid-stream, coincident with in_rdy&in_vld -> sample dropped, state zeroed, out_vld = 0 the next cycle. The phase restarts and behaviour matches a fresh-reset golden model.
